// File: rtl/life_pkg.sv
// Shared definitions for the life array readout logic.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    STEP
  } state_t;

  localparam int unsigned CELLS_PER_COL = 4;

  function automatic int unsigned pop_width(input int unsigned n);
    return $clog2(CELLS_PER_COL * n + 1);
  endfunction

endpackage

// File: rtl/life_popcount4.sv
// Combinational population count of one 4-cell column.
module life_popcount4 (
  input  logic [3:0] bits,
  output logic [2:0] count
);

  assign count = {2'b00, bits[0]} + {2'b00, bits[1]}
               + {2'b00, bits[2]} + {2'b00, bits[3]};

endmodule

// File: rtl/life_scan_out.sv
// Snapshot the life columns, stream them one column per beat, count live cells,
// and optionally pulse the array enable once the stream completes.
module life_scan_out
  import life_pkg::*;
#(
  parameter  int unsigned NCOLS = 4,
  localparam int unsigned CW    = $clog2(NCOLS),
  localparam int unsigned PW    = pop_width(NCOLS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CELLS_PER_COL*NCOLS-1:0]     alive_cols,
  input  logic                               start,
  input  logic                               advance,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [CELLS_PER_COL-1:0]           out_data,
  output logic [CW-1:0]                      out_col,
  output logic                               out_last,
  output logic                               step,
  output logic [PW-1:0]                      pop_count,
  output logic                               pop_valid,
  output logic                               busy
);

  state_t                   state_q, state_d;
  logic [CELLS_PER_COL-1:0] snap_q [NCOLS];
  logic                     adv_q;
  logic [PW-1:0]            acc_q;
  logic [PW-1:0]            pop_q;
  logic [CW-1:0]            col_q;
  logic [2:0]               beat_pop;
  logic [PW-1:0]            acc_sum;
  logic                     xfer;
  logic                     at_last;

  life_popcount4 u_popcount (
    .bits  (out_data),
    .count (beat_pop)
  );

  assign at_last = (col_q == CW'(NCOLS - 1));
  assign xfer    = (state_q == SEND) && out_ready;
  assign acc_sum = acc_q + PW'(beat_pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SEND;
      SEND:    if (xfer && at_last) state_d = STEP;
      STEP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pop_count loads on the final transfer so it is already valid in the STEP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      adv_q   <= 1'b0;
      acc_q   <= '0;
      pop_q   <= '0;
      col_q   <= '0;
      for (int unsigned c = 0; c < NCOLS; c++) snap_q[c] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int unsigned c = 0; c < NCOLS; c++)
              snap_q[c] <= alive_cols[CELLS_PER_COL*c +: CELLS_PER_COL];
            adv_q <= advance;
            acc_q <= '0;
            col_q <= '0;
          end
        end
        SEND: begin
          if (xfer) begin
            acc_q <= acc_sum;
            if (at_last) begin
              pop_q <= acc_sum;
              col_q <= '0;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? snap_q[col_q] : '0;
  assign out_col   = out_valid ? col_q : '0;
  assign out_last  = out_valid && at_last;
  assign step      = (state_q == STEP) && adv_q;
  assign pop_valid = (state_q == STEP);
  assign pop_count = pop_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/life_scan_out.md
# life_scan_out

Snapshot-and-stream readout stage placed directly downstream of the 4-cell life columns. On request it freezes the `alive_col` outputs of all columns and streams them out one 4-bit column per beat over a valid/ready handshake. It accumulates the live-cell population of the snapshot. Optionally, it then issues a single-cycle `enable` pulse to the array to advance exactly one generation.

## Interface
- `NCOLS`, default 4: number of 4-cell columns in the array; minimum 2.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `alive_cols`  in  4*NCOLS  concatenated `alive_col` buses; column c occupies bits [4c+3:4c].
- `start`  in  1  request a snapshot; sampled only in IDLE.
- `advance`  in  1  sampled with an accepted `start`; 1 means pulse `step` after the stream completes.
- `out_ready`  in  1  downstream sink accepts the current beat.
- `out_valid`  out  1  beat available.
- `out_data`  out  4  snapshot column; bit r is row r.
- `out_col`  out  $clog2(NCOLS)  column index of the current beat.
- `out_last`  out  1  current beat is column NCOLS-1.
- `step`  out  1  one-cycle pulse wired to the columns' `enable`.
- `pop_count`  out  $clog2(4*NCOLS+1)  live-cell count of the last completed snapshot.
- `pop_valid`  out  1  one-cycle pulse when `pop_count` updates.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, SEND, STEP.
- IDLE:
  - `busy`=0.
  - When `start`=1: latch `alive_cols` into `snap`, latch `advance` into `adv_q`, clear `acc`, set `col`=0, go to SEND.
- SEND:
  - Outputs: `out_valid`=1, `out_data`=snap[col], `out_col`=col, `out_last`=(col==NCOLS-1).
  - A transfer occurs when `out_valid` and `out_ready` are both 1. On transfer, `acc` += popcount(`out_data`).
  - Non-last transfer: `col`++.
  - Last transfer: go to STEP.
  - `out_data`, `out_col` and `out_last` hold steady while `out_valid`=1 and `out_ready`=0.
- STEP:
  - `step`=`adv_q` for this single cycle.
  - `pop_count` <= final `acc`, which includes the last beat; `pop_valid`=1.
  - Go to IDLE.
- Arithmetic:
  - `acc` and `pop_count` are $clog2(4*NCOLS+1) bits wide; no overflow is possible.
  - The per-beat popcount is a 3-bit zero-extended add.
- Snapshot isolation: `alive_cols` changes after the start cycle never affect the stream. The array cannot change during the stream because this block alone drives `enable`.
- `start` while `busy`=1: ignored, with no queuing.
- `start` is level-sampled. If it is still high in the IDLE cycle after STEP, a new snapshot begins, taken after the `step` edge, so it holds the new generation.
- `out_ready` is a don't-care outside SEND.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_data`=0, `out_col`=0, `out_last`=0, `step`=0, `pop_count`=0, `pop_valid`=0, `busy`=0.
- Reset mid-stream aborts immediately: no `step`, and `pop_count` returns to 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from `out_ready` or `alive_cols` to any output.
- `start` accepted at edge t:
  - `busy`=1 and `out_valid`=1 from cycle t+1.
- With `out_ready` held at 1:
  - Beats occur in cycles t+1 through t+NCOLS.
  - `step` and `pop_valid` occur in cycle t+NCOLS+1.
  - IDLE is reached in cycle t+NCOLS+2.
- Each cycle with `out_ready`=0 during SEND adds exactly one cycle of latency.
- The array updates on the edge that ends the `step` cycle, so new `alive_cols` are visible from cycle t+NCOLS+2.

## Structure
- Shared package `life_pkg` holds:
  - the state enum (IDLE/SEND/STEP);
  - `CELLS_PER_COL`=4;
  - a function `pop_width(n)` returning $clog2(4*n+1).
- Sub-module `life_popcount4`: combinational 4-bit to 3-bit population count, instantiated once on `out_data`.
- Everything else lives in a single module.

## Test plan
- With NCOLS=4, `alive_cols`=16'h8421, `advance`=0, `out_ready`=1, pulse `start`:
  - beats in order are 1, 2, 4, 8 with `out_col` 0..3;
  - `out_last` is high only on beat 3;
  - `pop_count`=4 and `pop_valid` pulses at t+5;
  - `step` stays 0.
- Same stimulus with `advance`=1 and `alive_cols` changed to 16'hFFFF at t+2:
  - stream is still 1, 2, 4, 8;
  - exactly one `step` pulse at t+5.
- Backpressure: `out_ready` toggles 0/1 every cycle, `alive_cols`=16'hF0F0:
  - data holds while stalled;
  - beats are 0, F, 0, F;
  - `pop_count`=8 at t+9.
- `start` pulsed again during SEND:
  - ignored;
  - exactly 4 beats and 1 `pop_valid`.
- `reset` asserted during beat 2:
  - next cycle all outputs are 0 and state is IDLE;
  - no `step`;
  - a subsequent `start` produces a full, correct stream.
- Blinker: load a vertical blinker through the column write path; `start` held high with `advance`=1 for 3 runs:
  - `pop_count`=3 each run;
  - the streamed pattern alternates between vertical and horizontal.
